port_group_allocator: RTL and testbench

PORT_GROUP_ALLOCATOR -- requirements
Module: port_group_allocator

---
 rtl/port_group_allocator_pkg.sv | 20 ++
 rtl/port_group_allocator_rr_first_free.sv | 31 +++
 rtl/port_group_allocator.sv | 142 ++++++++++++++
 tb/tb_port_group_allocator.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_group_allocator_pkg.sv
// Shared vector-core definitions: default port counts, instruction-type width
// and the index types used for write-port groups and VRF read ports.
package port_group_allocator_pkg;

    localparam int W_PORTS_NUM_DEF = 4;
    localparam int R_PORTS_NUM_DEF = 2 * W_PORTS_NUM_DEF;
    localparam int INSTR_TYPES_DEF = 12;

    localparam int GRP_IDX_W  = $clog2(W_PORTS_NUM_DEF);
    localparam int PORT_IDX_W = $clog2(R_PORTS_NUM_DEF);

    typedef logic [GRP_IDX_W-1:0]  grp_idx_t;
    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    // Each group owns read ports 2g and 2g+1; operand 3 borrows the odd one.
    function automatic port_idx_t op3_port_of(input grp_idx_t grp);
        return {grp, 1'b1};
    endfunction

endpackage

// File: rtl/port_group_allocator_rr_first_free.sv
// Round-robin first-free search: returns the first set bit of mask found
// scanning upward from ptr, wrapping modulo N (N must be a power of two).
module rr_first_free
    import port_group_allocator_pkg::*;
#(
    parameter int N  = W_PORTS_NUM_DEF,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] index,
    output logic          found
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        index = ptr;
        found = 1'b0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr + IW'(i);
            if (mask[cand]) begin
                index = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_group_allocator.sv
// Write-port group allocator: grants a free group round-robin with zero latency,
// optionally reserves a second group's odd read port for operand 3.
module port_group_allocator
    import port_group_allocator_pkg::*;
#(
    parameter int W_PORTS_NUM = W_PORTS_NUM_DEF,
    parameter int R_PORTS_NUM = R_PORTS_NUM_DEF,
    parameter int INSTR_TYPES = INSTR_TYPES_DEF
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [INSTR_TYPES-1:0]         instr_vld_i,
    output logic [INSTR_TYPES-1:0]         instr_rdy_o,
    input  logic                           op3_req_i,
    input  logic                           vrf_addr_vld_i,
    input  logic [W_PORTS_NUM-1:0]         port_done_i,
    output logic [W_PORTS_NUM-1:0]         start_o,
    output logic [$clog2(W_PORTS_NUM)-1:0] group_sel_o,
    output logic [$clog2(R_PORTS_NUM)-1:0] op3_port_sel_o,
    output logic                           op3_port_vld_o,
    output logic                           alloc_vld_o,
    output logic [W_PORTS_NUM-1:0]         busy_o,
    output logic [$clog2(W_PORTS_NUM):0]   free_cnt_o
);

    localparam int GW = $clog2(W_PORTS_NUM);
    localparam int PW = $clog2(R_PORTS_NUM);
    localparam int CW = GW + 1;

    logic [W_PORTS_NUM-1:0]         busy_q, busy_d;
    logic [W_PORTS_NUM-1:0]         resv_q, resv_d;
    logic [W_PORTS_NUM-1:0]         link_vld_q, link_vld_d;
    logic [W_PORTS_NUM-1:0][GW-1:0] link_idx_q, link_idx_d;
    logic [GW-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]                  free_cnt_q, free_cnt_d;

    logic [W_PORTS_NUM-1:0] free_q;
    logic [W_PORTS_NUM-1:0] free_d;
    logic [GW-1:0]          grant_idx;
    logic                   grant_found;
    logic [GW-1:0]          op3_grp;
    logic                   rdy;
    logic                   alloc;
    logic                   op3_take;

    assign free_q = ~busy_q & ~resv_q;

    rr_first_free #(
        .N  (W_PORTS_NUM),
        .IW (GW)
    ) u_rr_first_free (
        .mask  (free_q),
        .ptr   (rr_ptr_q),
        .index (grant_idx),
        .found (grant_found)
    );

    // Handshake: ready is derived from registered state and op3_req_i only, never
    // from instr_vld_i; an allocation fires on any vld&rdy bit with a valid VRF address.
    always_comb begin
        rdy      = (free_cnt_q != '0) && (!op3_req_i || (free_cnt_q >= CW'(2)));
        alloc    = (|(instr_vld_i & {INSTR_TYPES{rdy}})) && vrf_addr_vld_i && grant_found;
        op3_take = alloc && op3_req_i;
    end

    always_comb begin
        op3_grp = '0;
        for (int g = W_PORTS_NUM - 1; g >= 0; g--) begin
            if (free_q[g] && (GW'(g) != grant_idx)) begin
                op3_grp = GW'(g);
            end
        end
    end

    // Clears are applied first so a same-cycle set on the same bit wins.
    always_comb begin
        busy_d     = busy_q;
        resv_d     = resv_q;
        link_vld_d = link_vld_q;
        link_idx_d = link_idx_q;
        rr_ptr_d   = rr_ptr_q;
        for (int g = 0; g < W_PORTS_NUM; g++) begin
            if (port_done_i[g] && busy_q[g]) begin
                busy_d[g] = 1'b0;
                if (link_vld_q[g]) begin
                    resv_d[link_idx_q[g]] = 1'b0;
                    link_vld_d[g]         = 1'b0;
                end
            end
        end
        if (alloc) begin
            busy_d[grant_idx]     = 1'b1;
            link_vld_d[grant_idx] = op3_req_i;
            link_idx_d[grant_idx] = op3_grp;
            rr_ptr_d              = grant_idx + GW'(1);
            if (op3_req_i) begin
                resv_d[op3_grp] = 1'b1;
            end
        end
    end

    always_comb begin
        free_d     = ~busy_d & ~resv_d;
        free_cnt_d = '0;
        for (int g = 0; g < W_PORTS_NUM; g++) begin
            free_cnt_d = free_cnt_d + CW'(free_d[g]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q     <= '0;
            resv_q     <= '0;
            link_vld_q <= '0;
            link_idx_q <= '0;
            rr_ptr_q   <= '0;
            free_cnt_q <= CW'(W_PORTS_NUM);
        end else begin
            busy_q     <= busy_d;
            resv_q     <= resv_d;
            link_vld_q <= link_vld_d;
            link_idx_q <= link_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    always_comb begin
        instr_rdy_o    = {INSTR_TYPES{rdy}};
        alloc_vld_o    = alloc;
        start_o        = '0;
        if (alloc) begin
            start_o[grant_idx] = 1'b1;
        end
        group_sel_o    = grant_idx;
        op3_port_sel_o = op3_take ? PW'({op3_grp, 1'b1}) : '0;
        op3_port_vld_o = op3_take;
        busy_o         = busy_q;
        free_cnt_o     = free_cnt_q;
    end

endmodule

// File: tb/tb_port_group_allocator.sv
// Bench for port_group_allocator: directed pins plus randomized traffic, all
// outputs compared each cycle against a group-level behavioural model.
module tb_port_group_allocator;

    localparam int W = 4;
    localparam int R = 8;
    localparam int T = 12;

    logic          clk = 1'b0;
    logic          rstn;
    logic [T-1:0]  instr_vld_i;
    logic [T-1:0]  instr_rdy_o;
    logic          op3_req_i;
    logic          vrf_addr_vld_i;
    logic [W-1:0]  port_done_i;
    logic [W-1:0]  start_o;
    logic [1:0]    group_sel_o;
    logic [2:0]    op3_port_sel_o;
    logic          op3_port_vld_o;
    logic          alloc_vld_o;
    logic [W-1:0]  busy_o;
    logic [2:0]    free_cnt_o;

    port_group_allocator #(
        .W_PORTS_NUM (W),
        .R_PORTS_NUM (R),
        .INSTR_TYPES (T)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .instr_vld_i    (instr_vld_i),
        .instr_rdy_o    (instr_rdy_o),
        .op3_req_i      (op3_req_i),
        .vrf_addr_vld_i (vrf_addr_vld_i),
        .port_done_i    (port_done_i),
        .start_o        (start_o),
        .group_sel_o    (group_sel_o),
        .op3_port_sel_o (op3_port_sel_o),
        .op3_port_vld_o (op3_port_vld_o),
        .alloc_vld_o    (alloc_vld_o),
        .busy_o         (busy_o),
        .free_cnt_o     (free_cnt_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    bit m_busy[W];
    bit m_resv[W];
    bit m_lvld[W];
    int m_lidx[W];
    int m_rr;
    bit e_alloc;
    int e_grant;
    int e_op3g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_free(input int g);
        return !m_busy[g] && !m_resv[g];
    endfunction

    function automatic int nfree();
        int n = 0;
        for (int g = 0; g < W; g++) if (is_free(g)) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < W; g++) begin
            m_busy[g] = 0;
            m_resv[g] = 0;
            m_lvld[g] = 0;
            m_lidx[g] = 0;
        end
        m_rr = 0;
    endtask

    task automatic compare();
        int nf;
        bit e_rdy;
        bit take;
        logic [31:0] e_busy;
        nf      = nfree();
        e_rdy   = (nf >= 1) && (!op3_req_i || nf >= 2);
        e_alloc = (instr_vld_i != '0) && e_rdy && vrf_addr_vld_i;
        e_grant = -1;
        for (int k = 0; k < W; k++) begin
            if (e_grant < 0 && is_free((m_rr + k) % W)) e_grant = (m_rr + k) % W;
        end
        e_op3g = -1;
        for (int g = 0; g < W; g++) begin
            if (e_op3g < 0 && is_free(g) && g != e_grant) e_op3g = g;
        end
        take   = e_alloc && op3_req_i;
        e_busy = 0;
        for (int g = 0; g < W; g++) if (m_busy[g]) e_busy = e_busy | (32'd1 << g);
        chk("rdy", 32'(instr_rdy_o), e_rdy ? 32'hfff : 32'h0);
        chk("alloc", 32'(alloc_vld_o), 32'(e_alloc));
        chk("start", 32'(start_o), e_alloc ? (32'd1 << e_grant) : 32'd0);
        if (e_alloc) chk("group_sel", 32'(group_sel_o), 32'(e_grant));
        chk("op3_vld", 32'(op3_port_vld_o), 32'(take));
        chk("op3_sel", 32'(op3_port_sel_o), take ? 32'(2 * e_op3g + 1) : 32'd0);
        chk("busy", 32'(busy_o), e_busy);
        chk("free_cnt", 32'(free_cnt_o), 32'(nf));
    endtask

    task automatic model_step();
        for (int g = 0; g < W; g++) begin
            if (port_done_i[g] && m_busy[g]) begin
                m_busy[g] = 0;
                if (m_lvld[g]) begin
                    m_resv[m_lidx[g]] = 0;
                    m_lvld[g] = 0;
                end
            end
        end
        if (e_alloc) begin
            m_busy[e_grant] = 1;
            m_lvld[e_grant] = op3_req_i;
            m_lidx[e_grant] = e_op3g;
            if (op3_req_i) m_resv[e_op3g] = 1;
            m_rr = (e_grant + 1) % W;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply(input logic [T-1:0] v, input logic o, input logic a, input logic [W-1:0] d);
        @(negedge clk);
        instr_vld_i    = v;
        op3_req_i      = o;
        vrf_addr_vld_i = a;
        port_done_i    = d;
        #1;
        compare();
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        instr_vld_i    = '0;
        op3_req_i      = 1'b0;
        vrf_addr_vld_i = 1'b0;
        port_done_i    = '0;
        rstn           = 1'b0;
        model_reset();
        #1;
        compare();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_free", 32'(free_cnt_o), 32'd4);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [T-1:0] v;
        logic [W-1:0] d;
        rstn           = 1'b0;
        instr_vld_i    = '0;
        op3_req_i      = 1'b0;
        vrf_addr_vld_i = 1'b0;
        port_done_i    = '0;
        model_reset();
        do_reset();
        chk("rst_rdy", 32'(instr_rdy_o), 32'hfff);

        // single allocation from reset
        apply(12'h001, 1'b0, 1'b1, 4'b0000);
        chk("first_start", 32'(start_o), 32'd1);
        chk("first_sel", 32'(group_sel_o), 32'd0);
        adv();
        apply(12'h000, 1'b0, 1'b0, 4'b0000);
        chk("first_busy", 32'(busy_o), 32'd1);
        chk("first_free", 32'(free_cnt_o), 32'd3);
        adv();

        // four back-to-back grants, then full
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(12'h010, 1'b0, 1'b1, 4'b0000);
            chk("b2b_start", 32'(start_o), 32'd1 << i);
            adv();
        end
        apply(12'hfff, 1'b0, 1'b1, 4'b0000);
        chk("full_rdy", 32'(instr_rdy_o), 32'd0);
        chk("full_start", 32'(start_o), 32'd0);
        adv();

        // done on group 2, next grant goes to 2
        apply(12'h000, 1'b0, 1'b0, 4'b0100);
        adv();
        apply(12'h002, 1'b0, 1'b1, 4'b0000);
        chk("done2_free", 32'(free_cnt_o), 32'd1);
        chk("done2_start", 32'(start_o), 32'd4);
        adv();

        // done and grant of group 1 together
        apply(12'h000, 1'b0, 1'b0, 4'b0010);
        adv();
        apply(12'h004, 1'b0, 1'b1, 4'b0010);
        chk("g1_start", 32'(start_o), 32'd2);
        adv();
        apply(12'h000, 1'b0, 1'b0, 4'b0000);
        chk("g1_busy", 32'(busy_o), 32'hf);
        adv();

        // reset with busy=1011, then stale done
        apply(12'h000, 1'b0, 1'b0, 4'b0100);
        adv();
        apply(12'h000, 1'b0, 1'b0, 4'b0000);
        chk("pre_rst_busy", 32'(busy_o), 32'hb);
        adv();
        do_reset();
        apply(12'h000, 1'b0, 1'b0, 4'b1011);
        adv();
        apply(12'h000, 1'b0, 1'b0, 4'b0000);
        chk("stale_busy", 32'(busy_o), 32'd0);
        chk("stale_free", 32'(free_cnt_o), 32'd4);
        adv();

        // op3 reservation and its release through the link
        do_reset();
        apply(12'h800, 1'b1, 1'b1, 4'b0000);
        chk("op3_start", 32'(start_o), 32'd1);
        chk("op3_sel3", 32'(op3_port_sel_o), 32'd3);
        adv();
        apply(12'h001, 1'b0, 1'b1, 4'b0000);
        chk("op3_skip_resv", 32'(start_o), 32'd4);
        adv();
        apply(12'h001, 1'b1, 1'b1, 4'b0000);
        chk("op3_last_rdy", 32'(instr_rdy_o), 32'd0);
        adv();
        apply(12'h000, 1'b0, 1'b0, 4'b0001);
        adv();
        apply(12'h000, 1'b0, 1'b0, 4'b0000);
        chk("op3_release", 32'(free_cnt_o), 32'd3);
        adv();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                v = T'($urandom);
                if ($urandom_range(0, 3) == 0) v = '0;
                d = W'($urandom) & W'($urandom);
                apply(v, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), d);
                adv();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
